// File: rtl/lc3_operate_sequencer.sv
// Multi-cycle sequencer for LC-3 operate-class instructions (ADD, AND, NOT, LEA).
// One instruction per transaction: IDLE -> DECODE -> EXEC -> WB -> IDLE.
module lc3_operate_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] pc_in,
  output logic [2:0]       sr1_addr,
  output logic [2:0]       sr2_addr,
  input  logic [WIDTH-1:0] sr1_data,
  input  logic [WIDTH-1:0] sr2_data,
  output logic [1:0]       sext_sel,
  output logic [10:0]      sext_field,
  input  logic [WIDTH-1:0] sext_value,
  output logic             wb_en,
  output logic [2:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [2:0]       nzp,
  output logic             busy,
  output logic             illegal
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, so valid raised while busy is simply not taken.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] SEL_IMM5  = 2'd0;
  localparam logic [1:0] SEL_PCOF9 = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [15:0]      ir_q,      ir_d;
  logic [WIDTH-1:0] pc_q,      pc_d;
  logic [2:0]       wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [2:0]       nzp_q,     nzp_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       opcode;
  logic             accept;
  logic             op_supported;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] exec_result;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])    return 3'b100;
    else if (v == '0)  return 3'b010;
    else               return 3'b001;
  endfunction

  assign opcode = ir_q[15:12];
  assign accept = instr_valid && (state_q == S_IDLE);

  always_comb begin
    op_supported = 1'b0;
    case (instr[15:12])
      OP_ADD, OP_AND, OP_NOT, OP_LEA: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  end

  // Bit 5 picks immediate mode for ADD/AND; NOT and LEA ignore operand_b's source.
  assign operand_b = ir_q[5] ? sext_value : sr2_data;

  always_comb begin
    exec_result = '0;
    case (opcode)
      OP_ADD:  exec_result = sr1_data + operand_b;
      OP_AND:  exec_result = sr1_data & operand_b;
      OP_NOT:  exec_result = ~sr1_data;
      OP_LEA:  exec_result = pc_q + sext_value;
      default: exec_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    nzp_d     = nzp_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ir_d = instr;
          pc_d = pc_in;
          if (op_supported) state_d   = S_DECODE;
          else              illegal_d = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        wb_data_d = exec_result;
        wb_addr_d = ir_q[11:9];
        state_d   = S_WB;
      end
      S_WB: begin
        if (opcode != OP_LEA) nzp_d = nzp_of(wb_data_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      nzp_q     <= 3'b010;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      nzp_q     <= nzp_d;
      illegal_q <= illegal_d;
    end
  end

  // Read addresses and extender select are held from DECODE through WB so the
  // combinational register-file and extender outputs stay stable into EXEC.
  assign busy        = (state_q != S_IDLE);
  assign instr_ready = (state_q == S_IDLE);
  assign sr1_addr    = busy ? ir_q[8:6] : 3'd0;
  assign sr2_addr    = busy ? ir_q[2:0] : 3'd0;
  assign sext_sel    = (busy && opcode == OP_LEA) ? SEL_PCOF9 : SEL_IMM5;
  assign sext_field  = ir_q[10:0];
  assign wb_en       = (state_q == S_WB);
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign nzp         = nzp_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_lc3_operate_sequencer.sv
// Directed bench for lc3_operate_sequencer: vector table plus illegal-opcode
// and mid-transaction reset sequences; writebacks are also scoreboarded.
module tb_lc3_operate_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] pc_in;
  logic [2:0]  sr1_addr;
  logic [2:0]  sr2_addr;
  logic [15:0] sr1_data;
  logic [15:0] sr2_data;
  logic [1:0]  sext_sel;
  logic [10:0] sext_field;
  logic [15:0] sext_value;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  nzp;
  logic        busy;
  logic        illegal;

  lc3_operate_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_in(pc_in),
    .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
    .sr1_data(sr1_data), .sr2_data(sr2_data),
    .sext_sel(sext_sel), .sext_field(sext_field), .sext_value(sext_value),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .nzp(nzp), .busy(busy), .illegal(illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] sext;
    logic [1:0]  sel;
    logic [2:0]  sr1a;
    logic [2:0]  sr2a;
    logic [2:0]  dr;
    logic [15:0] res;
    logic [2:0]  nzp;
  } vec_t;

  vec_t        vecs[9];
  int          n_checks;
  int          n_errors;
  int          wb_seen;
  int          wb_expected;
  logic [2:0]  cur_nzp;
  logic [15:0] last_wb;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every wb_en strobe must match the oldest expected result
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      wb_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_unexpected: got wb_data 0x%0h with no writeback expected at %0t", wb_data, $time);
      end else begin
        check("wb_data_sb", {16'h0, wb_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // driver: one full transaction from accept to return to IDLE
  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = v.instr;
    pc_in       = v.pc;
    sr1_data    = v.sr1;
    sr2_data    = v.sr2;
    sext_value  = v.sext;
    check({tag, "_ready_idle"}, {31'h0, instr_ready}, 32'd1);
    exp_q.push_back(v.res);
    wb_expected++;
    @(negedge clk);  // DECODE
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check({tag, "_ready_dec"}, {31'h0, instr_ready}, 32'd0);
    check({tag, "_busy_dec"}, {31'h0, busy}, 32'd1);
    check({tag, "_sr1a"}, {29'h0, sr1_addr}, {29'h0, v.sr1a});
    check({tag, "_sr2a"}, {29'h0, sr2_addr}, {29'h0, v.sr2a});
    check({tag, "_sel"}, {30'h0, sext_sel}, {30'h0, v.sel});
    check({tag, "_field"}, {21'h0, sext_field}, {21'h0, v.instr[10:0]});
    check({tag, "_wben_dec"}, {31'h0, wb_en}, 32'd0);
    check({tag, "_hold_dec"}, {16'h0, wb_data}, {16'h0, last_wb});
    @(negedge clk);  // EXEC
    check({tag, "_wben_exec"}, {31'h0, wb_en}, 32'd0);
    check({tag, "_hold_exec"}, {16'h0, wb_data}, {16'h0, last_wb});
    check({tag, "_field_exec"}, {21'h0, sext_field}, {21'h0, v.instr[10:0]});
    @(negedge clk);  // WB
    check({tag, "_wben_wb"}, {31'h0, wb_en}, 32'd1);
    check({tag, "_wbaddr"}, {29'h0, wb_addr}, {29'h0, v.dr});
    check({tag, "_wbdata"}, {16'h0, wb_data}, {16'h0, v.res});
    check({tag, "_nzp_wb"}, {29'h0, nzp}, {29'h0, cur_nzp});
    @(negedge clk);  // back in IDLE
    check({tag, "_wben_after"}, {31'h0, wb_en}, 32'd0);
    check({tag, "_ready_after"}, {31'h0, instr_ready}, 32'd1);
    check({tag, "_busy_after"}, {31'h0, busy}, 32'd0);
    check({tag, "_nzp"}, {29'h0, nzp}, {29'h0, v.nzp});
    check({tag, "_hold_after"}, {16'h0, wb_data}, {16'h0, v.res});
    cur_nzp = v.nzp;
    last_wb = v.res;
  endtask

  initial begin
    //            instr     pc        sr1       sr2       sext      sel   sr1a  sr2a  dr    res       nzp
    vecs[0] = '{16'h12BD, 16'h0000, 16'h0005, 16'h1111, 16'hFFFD, 2'd0, 3'd2, 3'd5, 3'd1, 16'h0002, 3'b001};
    vecs[1] = '{16'h5705, 16'h0000, 16'h00F0, 16'h0F0F, 16'hFFFF, 2'd0, 3'd4, 3'd5, 3'd3, 16'h0000, 3'b010};
    vecs[2] = '{16'h91FF, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 2'd0, 3'd7, 3'd7, 3'd0, 16'hFFFF, 3'b100};
    vecs[3] = '{16'hEDFF, 16'h3001, 16'h1234, 16'h4321, 16'hFFFF, 2'd2, 3'd7, 3'd7, 3'd6, 16'h3000, 3'b100};
    vecs[4] = '{16'h54EF, 16'h0000, 16'h1234, 16'hFFFF, 16'h000F, 2'd0, 3'd3, 3'd7, 3'd2, 16'h0004, 3'b001};
    vecs[5] = '{16'h1E01, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 2'd0, 3'd0, 3'd1, 3'd7, 16'h8000, 3'b100};
    vecs[6] = '{16'h1B61, 16'h0000, 16'hFFFF, 16'h1234, 16'h0001, 2'd0, 3'd5, 3'd1, 3'd5, 16'h0000, 3'b010};
    vecs[7] = '{16'hE205, 16'h0010, 16'hAAAA, 16'hBBBB, 16'h0005, 2'd2, 3'd0, 3'd5, 3'd1, 16'h0015, 3'b010};
    vecs[8] = '{16'h96FF, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 2'd0, 3'd3, 3'd7, 3'd3, 16'h7FFF, 3'b001};

    n_checks = 0; n_errors = 0; wb_seen = 0; wb_expected = 0;
    cur_nzp = 3'b010; last_wb = 16'h0000;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; pc_in = 16'h0000;
    sr1_data = 16'h0000; sr2_data = 16'h0000; sext_value = 16'h0000;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, instr_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_wben", {31'h0, wb_en}, 32'd0);
    check("rst_illegal", {31'h0, illegal}, 32'd0);
    check("rst_wbaddr", {29'h0, wb_addr}, 32'd0);
    check("rst_wbdata", {16'h0, wb_data}, 32'd0);
    check("rst_nzp", {29'h0, nzp}, 32'd2);
    check("rst_sr1a", {29'h0, sr1_addr}, 32'd0);
    check("rst_sr2a", {29'h0, sr2_addr}, 32'd0);
    check("rst_sel", {30'h0, sext_sel}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // unsupported opcodes: one-cycle illegal pulse, no writeback, stays ready
    begin
      logic [15:0] bad_ops[3];
      bad_ops[0] = 16'h0000; bad_ops[1] = 16'hF025; bad_ops[2] = 16'h6000;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = bad_ops[k];
        @(negedge clk);
        instr_valid = 1'b0;
        check($sformatf("ill%0d_pulse", k), {31'h0, illegal}, 32'd1);
        check($sformatf("ill%0d_ready", k), {31'h0, instr_ready}, 32'd1);
        check($sformatf("ill%0d_busy", k), {31'h0, busy}, 32'd0);
        @(negedge clk);
        check($sformatf("ill%0d_clear", k), {31'h0, illegal}, 32'd0);
        check($sformatf("ill%0d_wben", k), {31'h0, wb_en}, 32'd0);
      end
    end

    // BR then a back-to-back ADD held valid into the very next cycle
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h0000;
    @(negedge clk);
    check("b2b_illegal", {31'h0, illegal}, 32'd1);
    check("b2b_ready", {31'h0, instr_ready}, 32'd1);
    instr      = 16'h12BD;
    sr1_data   = 16'h0005;
    sr2_data   = 16'h1111;
    sext_value = 16'hFFFD;
    exp_q.push_back(16'h0002);
    wb_expected++;
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b_illegal_clr", {31'h0, illegal}, 32'd0);
    check("b2b_busy", {31'h0, busy}, 32'd1);
    @(negedge clk);
    check("b2b_wben_exec", {31'h0, wb_en}, 32'd0);
    @(negedge clk);
    check("b2b_wben", {31'h0, wb_en}, 32'd1);
    check("b2b_wbaddr", {29'h0, wb_addr}, 32'd1);
    check("b2b_wbdata", {16'h0, wb_data}, 32'h0002);
    @(negedge clk);
    check("b2b_nzp", {29'h0, nzp}, 32'b001);
    cur_nzp = 3'b001;

    // async reset during EXEC aborts the transaction
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h1E01;
    sr1_data    = 16'h7FFF;
    sr2_data    = 16'h0001;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_exec", {31'h0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", {31'h0, instr_ready}, 32'd1);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_nzp", {29'h0, nzp}, 32'b010);
    check("abort_wben", {31'h0, wb_en}, 32'd0);
    check("abort_wbdata", {16'h0, wb_data}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_wben_hold", {31'h0, wb_en}, 32'd0);
    rst_n   = 1'b1;
    cur_nzp = 3'b010;
    last_wb = 16'h0000;
    @(negedge clk);
    check("abort_nowb", {31'h0, wb_en}, 32'd0);
    run_op(vecs[7], "post_rst_lea");
    run_op(vecs[5], "post_rst_add");

    repeat (2) @(negedge clk);
    check("wb_count", wb_seen, wb_expected);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
